// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the neuron layer sequencer and its helpers:
//   - state_e : layer sequencer FSM states
//   - ACC_W / WGT_W / PIX_W / N_IN : Neuron datapath geometry
//   - acc_t   : Neuron accumulator / result type
//   - cnt_width() : width of a down-counter able to hold max(a, b)
// No ports (package).
// -----------------------------------------------------------------------------
package neuron_pkg;

  localparam int ACC_W = 26;  // Neuron Out width
  localparam int WGT_W = 19;  // one weight
  localparam int PIX_W = 10;  // one input pixel
  localparam int N_IN  = 32;  // inputs per neuron

  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOADW = 3'd2,
    S_DRIVE = 3'd3,
    S_WAIT  = 3'd4,
    S_WRITE = 3'd5,
    S_FIN   = 3'd6
  } state_e;

  // Bits needed for a counter that is loaded with values up to max(a, b).
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/seq_cycle_counter.sv
// -----------------------------------------------------------------------------
// seq_cycle_counter
// Loadable saturating down-counter. The sequencer loads it on every state
// entry and uses zero_o to end timed states (input-valid hold, output wait).
// Ports:
//   clk_i       : clock
//   rst_ni      : asynchronous active-low reset (count -> 0)
//   load_i      : load load_val_i this cycle (takes priority over counting)
//   load_val_i  : value to load
//   zero_o      : count is zero
// -----------------------------------------------------------------------------
module seq_cycle_counter
  import neuron_pkg::*;
#(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/neuron_layer_sequencer.sv
// -----------------------------------------------------------------------------
// neuron_layer_sequencer
// Runs one Neuron across every neuron of a fully-connected layer: fetch the
// weight set, hold Input_valid for IV_HOLD cycles, wait (bounded) for
// Output_valid, write the result to the layer buffer, repeat.
// Optional feature macro: NEURON_SEQ_RELU_EN -- when defined, negative Neuron
// results are clamped to zero at capture (no added latency).
// Ports:
//   clk, GlobalReset_n        : clock, async active-low reset
//   start                     : run request (accepted in IDLE only)
//   busy, done, err_timeout   : status (done = 1-cycle end pulse, err sticky)
//   wgt_rd_en/_addr, wgt_rd_valid : weight memory read handshake
//   nrn_input_valid           : to Neuron Input_valid
//   nrn_output_valid, nrn_out : from Neuron Output_valid / Out
//   res_wr_en/_addr/_data     : result buffer write port
// All outputs are registered; they are computed from the next state so they
// line up with the state they belong to.
// -----------------------------------------------------------------------------
module neuron_layer_sequencer
  import neuron_pkg::*;
#(
  parameter int NUM_NEURONS = 10,
  parameter int ACC_W       = 26,
  parameter int IV_HOLD     = 10,
  parameter int TIMEOUT     = 64,
  parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
  input  logic             clk,
  input  logic             GlobalReset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err_timeout,
  output logic             wgt_rd_en,
  output logic [IDX_W-1:0] wgt_rd_addr,
  input  logic             wgt_rd_valid,
  output logic             nrn_input_valid,
  input  logic             nrn_output_valid,
  input  logic [ACC_W-1:0] nrn_out,
  output logic             res_wr_en,
  output logic [IDX_W-1:0] res_wr_addr,
  output logic [ACC_W-1:0] res_wr_data
);

  localparam int               CNT_W   = cnt_width(IV_HOLD, TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(IV_HOLD - 1);
  localparam logic [CNT_W-1:0] TO_LD   = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(NUM_NEURONS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_set;
  logic             cnt_zero;
  logic [ACC_W-1:0] nrn_res;

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             wgt_rd_en_q, wgt_rd_en_d;
  logic [IDX_W-1:0] wgt_rd_addr_q, wgt_rd_addr_d;
  logic             niv_q, niv_d;
  logic             res_wr_en_q, res_wr_en_d;
  logic [IDX_W-1:0] res_wr_addr_q, res_wr_addr_d;
  logic [ACC_W-1:0] res_wr_data_q, res_wr_data_d;

`ifdef NEURON_SEQ_RELU_EN
  assign nrn_res = nrn_out[ACC_W-1] ? '0 : nrn_out;
`else
  assign nrn_res = nrn_out;
`endif

  // One counter serves both timed states: it is reloaded on any state change,
  // with the DRIVE hold length or the WAIT budget. Other states ignore it.
  seq_cycle_counter #(.W(CNT_W)) u_cnt (
    .clk_i      (clk),
    .rst_ni     (GlobalReset_n),
    .load_i     (state_d != state_q),
    .load_val_i ((state_d == S_DRIVE) ? HOLD_LD : TO_LD),
    .zero_o     (cnt_zero)
  );

  // State register (plus index and registered outputs).
  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      wgt_rd_en_q   <= 1'b0;
      wgt_rd_addr_q <= '0;
      niv_q         <= 1'b0;
      res_wr_en_q   <= 1'b0;
      res_wr_addr_q <= '0;
      res_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      wgt_rd_en_q   <= wgt_rd_en_d;
      wgt_rd_addr_q <= wgt_rd_addr_d;
      niv_q         <= niv_d;
      res_wr_en_q   <= res_wr_en_d;
      res_wr_addr_q <= res_wr_addr_d;
      res_wr_data_q <= res_wr_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FETCH;
        idx_d   = '0;
      end
      S_FETCH: state_d = S_LOADW;
      S_LOADW: if (wgt_rd_valid) state_d = S_DRIVE;
      // Output_valid is not looked at here: it may still be high from the
      // previous neuron.
      S_DRIVE: if (cnt_zero) state_d = S_WAIT;
      // A valid on the final budgeted cycle still wins over the timeout.
      S_WAIT: begin
        if (nrn_output_valid) begin
          state_d = S_WRITE;
        end else if (cnt_zero) begin
          state_d = S_FIN;
          err_set = 1'b1;
        end
      end
      S_WRITE: begin
        if (idx_q == LAST) begin
          state_d = S_FIN;
        end else begin
          state_d = S_FETCH;
          idx_d   = idx_q + 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the output registers.
  always_comb begin
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_FIN);
    wgt_rd_en_d   = (state_d == S_FETCH);
    wgt_rd_addr_d = wgt_rd_en_d ? idx_d : wgt_rd_addr_q;
    niv_d         = (state_d == S_DRIVE);
    res_wr_en_d   = (state_d == S_WRITE);
    res_wr_addr_d = res_wr_en_d ? idx_q : res_wr_addr_q;
    // WRITE is only entered from WAIT on a valid, so this is the capture.
    res_wr_data_d = res_wr_en_d ? nrn_res : res_wr_data_q;
    err_d         = err_q;
    if (state_q == S_IDLE && start) err_d = 1'b0;
    else if (err_set)               err_d = 1'b1;
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign err_timeout     = err_q;
  assign wgt_rd_en       = wgt_rd_en_q;
  assign wgt_rd_addr     = wgt_rd_addr_q;
  assign nrn_input_valid = niv_q;
  assign res_wr_en       = res_wr_en_q;
  assign res_wr_addr     = res_wr_addr_q;
  assign res_wr_data     = res_wr_data_q;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Layer-level bench for neuron_layer_sequencer with a 3-neuron layer.
// A behavioural weight memory (valid 2 cycles after the read strobe) and a
// Neuron model (valid m_delay cycles after Input_valid falls) respond to the
// DUT; monitors log writes, reads and timing; a table of layer scenarios is
// run and checked, followed by hand-written corner sequences.
module tb_neuron_layer_sequencer;

  localparam int NN  = 3;
  localparam int AW  = 26;
  localparam int IVH = 10;
  localparam int TO  = 64;
  localparam int IW  = 2;
`ifdef NEURON_SEQ_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          GlobalReset_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, err_timeout, wgt_rd_en, nrn_input_valid, res_wr_en;
  logic [IW-1:0] wgt_rd_addr, res_wr_addr;
  logic          wgt_rd_valid = 1'b0;
  logic          nrn_output_valid = 1'b0;
  logic [AW-1:0] nrn_out = '0;
  logic [AW-1:0] res_wr_data;

  always #5 clk = ~clk;

  neuron_layer_sequencer #(
    .NUM_NEURONS(NN), .ACC_W(AW), .IV_HOLD(IVH), .TIMEOUT(TO), .IDX_W(IW)
  ) dut (
    .clk(clk), .GlobalReset_n(GlobalReset_n), .start(start), .busy(busy),
    .done(done), .err_timeout(err_timeout), .wgt_rd_en(wgt_rd_en),
    .wgt_rd_addr(wgt_rd_addr), .wgt_rd_valid(wgt_rd_valid),
    .nrn_input_valid(nrn_input_valid), .nrn_output_valid(nrn_output_valid),
    .nrn_out(nrn_out), .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr),
    .res_wr_data(res_wr_data)
  );

  // ---------------- scenario table ----------------
  // mode: 0 normal, 1 never valid, 2 stale valid held high through DRIVE
  typedef struct {
    string              name;
    int                 mode;
    int                 delay;
    logic [2:0][AW-1:0] v;    // Neuron Out per neuron
    logic [2:0][AW-1:0] e;    // required written data
    int                 nwr;  // required number of writes
    bit                 err;  // required err_timeout
  } vec_t;

  function automatic vec_t mk(input string n, input int m, input int d,
                              input logic [AW-1:0] v0, v1, v2, e0, e1, e2,
                              input int nwr, input bit err);
    vec_t r;
    r.name = n; r.mode = m; r.delay = d;
    r.v[0] = v0; r.v[1] = v1; r.v[2] = v2;
    r.e[0] = e0; r.e[1] = e1; r.e[2] = e2;
    r.nwr = nwr; r.err = err;
    return r;
  endfunction

  // ---------------- models ----------------
  int                 m_mode = 0;
  int                 m_delay = 28;
  logic [2:0][AW-1:0] m_vals = '0;
  int                 nidx = 0;
  int                 n_cd = 0;
  bit                 n_ivp = 1'b0;
  int                 w_cd = 0;

  always @(negedge clk) begin
    if (!GlobalReset_n) begin
      wgt_rd_valid = 1'b0; w_cd = 0;
    end else if (wgt_rd_en) begin
      wgt_rd_valid = 1'b0; w_cd = 2;
    end else if (w_cd > 0) begin
      w_cd--;
      if (w_cd == 0) wgt_rd_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!GlobalReset_n) begin
      nrn_output_valid = 1'b0; n_cd = 0; n_ivp = 1'b0;
    end else begin
      // stale mode: a bogus result is visible for the whole DRIVE window
      nrn_output_valid = (m_mode == 2) && nrn_input_valid;
      if (nrn_output_valid) nrn_out = 26'd999;
      if (n_ivp && !nrn_input_valid) n_cd = m_delay;
      if (n_cd > 0) begin
        n_cd--;
        if (n_cd == 0 && m_mode != 1 && nidx < NN) begin
          nrn_output_valid = 1'b1;
          nrn_out = m_vals[nidx];
          nidx++;
        end
      end
      n_ivp = nrn_input_valid;
    end
  end

  // ---------------- monitors ----------------
  int            cyc = 0;
  logic [IW-1:0] wr_addr[$];
  logic [AW-1:0] wr_data[$];
  int            wr_cyc[$];
  logic [IW-1:0] rd_addr[$];
  int            fall_cyc[$];
  int            iv_total = 0, iv_run = 0, done_cnt = 0, done_cyc = 0;
  bit            m_ivp = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (res_wr_en) begin
      wr_addr.push_back(res_wr_addr); wr_data.push_back(res_wr_data); wr_cyc.push_back(cyc);
    end
    if (wgt_rd_en) rd_addr.push_back(wgt_rd_addr);
    if (nrn_input_valid) begin iv_total++; iv_run++; end
    else iv_run = 0;
    if (m_ivp && !nrn_input_valid) fall_cyc.push_back(cyc);
    m_ivp = nrn_input_valid;
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  // ---------------- checking helpers ----------------
  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    rd_addr.delete(); fall_cyc.delete(); iv_total = 0;
  endtask

  task automatic wait_done(input string nm);
    int d0;
    bit ok;
    d0 = done_cnt; ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    chk({nm, ".done_seen"}, ok, 1);
  endtask

  task automatic set_model(input vec_t v);
    m_mode = v.mode; m_delay = v.delay; m_vals = v.v; nidx = 0;
  endtask

  task automatic pulse_start(input string nm);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, ".start_busy"}, busy, 1);
    chk({nm, ".start_rd_en"}, wgt_rd_en, 1);
    chk({nm, ".start_rd_addr"}, wgt_rd_addr, 0);
    chk({nm, ".err_cleared"}, err_timeout, 0);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, ".busy"}, busy, 0);
    chk({nm, ".done"}, done, 0);
    chk({nm, ".err"}, err_timeout, 0);
    chk({nm, ".rd_en"}, wgt_rd_en, 0);
    chk({nm, ".rd_addr"}, wgt_rd_addr, 0);
    chk({nm, ".iv"}, nrn_input_valid, 0);
    chk({nm, ".wr_en"}, res_wr_en, 0);
    chk({nm, ".wr_addr"}, res_wr_addr, 0);
    chk({nm, ".wr_data"}, res_wr_data, 0);
  endtask

  task automatic run_layer(input vec_t v);
    int visited;
    visited = v.nwr + (v.err ? 1 : 0);
    set_model(v);
    clear_logs();
    pulse_start(v.name);
    wait_done(v.name);
    chk({v.name, ".n_writes"}, wr_addr.size(), v.nwr);
    for (int i = 0; i < v.nwr && i < wr_addr.size(); i++) begin
      chk($sformatf("%s.wr_addr%0d", v.name, i), wr_addr[i], i);
      chk($sformatf("%s.wr_data%0d", v.name, i), wr_data[i], v.e[i]);
    end
    chk({v.name, ".err"}, err_timeout, v.err);
    chk({v.name, ".iv_cycles"}, iv_total, IVH * visited);
    chk({v.name, ".n_reads"}, rd_addr.size(), visited);
    if (v.nwr > 0 && wr_cyc.size() > 0 && fall_cyc.size() > 0) begin
      chk({v.name, ".wr_latency"}, wr_cyc[0] - fall_cyc[0], v.delay);
      chk({v.name, ".done_after_wr"}, done_cyc - wr_cyc[$], 1);
    end
    if (v.err && fall_cyc.size() > 0)
      chk({v.name, ".timeout_len"}, done_cyc - fall_cyc[$], TO);
    tick();
    chk({v.name, ".busy_after"}, busy, 0);
    chk({v.name, ".done_1cyc"}, done, 0);
  endtask

  // ---------------- test ----------------
  vec_t vecs[7];
  vec_t nom;

  initial begin
    vecs[0] = mk("nominal",   0, 28, 26'd100, 26'd200, 26'd300,
                 26'd100, 26'd200, 26'd300, 3, 1'b0);
    vecs[1] = mk("relu_neg",  0, 28, 26'h3FFFFF0, 26'h3FFFFF0, 26'h3FFFFF0,
                 RELU ? 26'h0 : 26'h3FFFFF0, RELU ? 26'h0 : 26'h3FFFFF0,
                 RELU ? 26'h0 : 26'h3FFFFF0, 3, 1'b0);
    vecs[2] = mk("relu_mix",  0, 5, 26'd5, 26'h3FFFFFF, 26'h1FFFFFF,
                 26'd5, RELU ? 26'h0 : 26'h3FFFFFF, 26'h1FFFFFF, 3, 1'b0);
    vecs[3] = mk("timeout",   1, 28, 26'd1, 26'd2, 26'd3, 26'd0, 26'd0, 26'd0, 0, 1'b1);
    vecs[4] = mk("last_cyc",  0, TO, 26'd1, 26'd2, 26'd3, 26'd1, 26'd2, 26'd3, 3, 1'b0);
    vecs[5] = mk("stale",     2, 11, 26'd7, 26'd8, 26'd9, 26'd7, 26'd8, 26'd9, 3, 1'b0);
    vecs[6] = mk("one_late",  0, TO + 1, 26'd4, 26'd5, 26'd6, 26'd0, 26'd0, 26'd0, 0, 1'b1);
    nom = vecs[0];

    // reset state
    tick(); tick();
    check_reset_vals("reset");
    GlobalReset_n = 1'b1;
    tick(); tick();
    chk("idle.busy", busy, 0);

    for (int i = 0; i < 7; i++) run_layer(vecs[i]);

    // start pulsed during WAIT of neuron 1 must not restart or be queued;
    // start coincident with done must also be ignored
    set_model(nom);
    clear_logs();
    pulse_start("busy_start");
    for (int i = 0; i < 500 && fall_cyc.size() < 2; i++) tick();
    chk("busy_start.reached_wait1", fall_cyc.size(), 2);
    tick(); tick(); tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done("busy_start");
    chk("busy_start.n_writes", wr_addr.size(), 3);
    chk("busy_start.n_reads", rd_addr.size(), 3);
    if (rd_addr.size() == 3) chk("busy_start.rd_addr2", rd_addr[2], 2);
    if (wr_addr.size() == 3) chk("busy_start.wr_addr2", wr_addr[2], 2);
    start = 1'b1; tick(); start = 1'b0;
    chk("start_at_done.busy", busy, 0);
    chk("start_at_done.rd_en", wgt_rd_en, 0);
    tick();
    chk("start_at_done.busy2", busy, 0);

    // reset in the 5th DRIVE cycle of neuron 0 (res_wr_data holds 300 here)
    set_model(nom);
    clear_logs();
    pulse_start("rst_drive");
    for (int i = 0; i < 200 && iv_run < 5; i++) tick();
    chk("rst_drive.reached", iv_run, 5);
    GlobalReset_n = 1'b0;
    #1;
    check_reset_vals("rst_drive");
    chk("rst_drive.no_write", wr_addr.size(), 0);
    tick(); tick();
    GlobalReset_n = 1'b1;
    tick();
    run_layer(nom);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
